// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types for the data-memory port arbiter
package ram_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int RAM_READ_LAT = 2;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

  // The requester that is not m
  function automatic master_id_t other_master(input master_id_t m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// rtl/ram_rd_tag_pipe.sv - read tag shift register matching BRAM read latency
module ram_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int LAT = RAM_READ_LAT
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output logic    head_valid,
  output rd_tag_t tail
);

  rd_tag_t pipe [LAT];

  // Shift tags one stage per cycle; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head_valid = pipe[0].valid;
  assign tail       = pipe[LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-master round-robin/lock arbiter for the data BRAM port
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = RAM_READ_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_en,
  output logic              ram_re,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_LOCKED = LOCKED;

  logic [0:0]        state;
  master_id_t        prio;
  master_id_t        owner;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  logic              any_gnt;
  master_id_t        win;
  logic              win_we;
  logic              win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              owner_req;
  rd_tag_t           tag_in;
  logic              head_valid;
  rd_tag_t           tail;

  // Combinational grant: lock owner only, else round-robin on contention
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (state == S_LOCKED) begin
        if (owner == M0) m0_gnt = m0_req;
        else             m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        if (prio == M0) m0_gnt = 1'b1;
        else            m1_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign win       = m1_gnt ? M1 : M0;
  assign win_we    = m1_gnt ? m1_we    : m0_we;
  assign win_lock  = m1_gnt ? m1_lock  : m0_lock;
  assign win_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign win_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign owner_req = (owner == M0) ? m0_req : m1_req;

  // Arbitration state: lock entry/exit and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      prio  <= M0;
      owner <= M0;
    end else if (state == S_LOCKED) begin
      if (!owner_req || (any_gnt && !win_lock)) begin
        state <= S_IDLE;
        prio  <= other_master(owner);
      end
    end else if (any_gnt) begin
      if (win_lock) begin
        state <= S_LOCKED;
        owner <= win;
      end else begin
        prio <= other_master(win);
      end
    end
  end

  // Remember the last issued address/data so the BRAM pins stay quiet when idle
  always_ff @(posedge clk) begin
    if (any_gnt) begin
      last_addr <= win_addr;
      last_din  <= win_wdata;
    end
  end

  assign ram_en   = any_gnt;
  assign ram_we   = any_gnt & win_we;
  assign ram_addr = any_gnt ? win_addr  : last_addr;
  assign ram_din  = any_gnt ? win_wdata : last_din;
  assign ram_rst  = reset;

  assign tag_in.valid = any_gnt & ~win_we;
  assign tag_in.id    = win;

  ram_rd_tag_pipe #(.LAT(READ_LAT)) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (tag_in),
    .head_valid (head_valid),
    .tail       (tail)
  );

  assign ram_re    = head_valid & ~reset;
  assign m0_rvalid = ~reset & tail.valid & (tail.id == M0);
  assign m1_rvalid = ~reset & tail.valid & (tail.id == M1);
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule
